alu1_flag_wb: RTL and testbench

Execute-to-writeback stage directly downstream of the ALU1 execute stage. It captures the ALU1 flag results (`alu1_flags`, `cmps_flags`, per-flag load enables, DF value) into one pipeline register. It commits them into the architectural flag register under a valid/ready handshake and saves/restores flags on interrupt entry/exit. It also returns CF/AF/DF to ALU1's `CF_in`/`AF_in`/`DF_in`, with optional forwarding of the in-flight result.

---
 rtl/alu1_flag_wb_pkg.sv | 41 ++++
 rtl/alu1_flag_wb_flag_shadow_reg.sv | 29 ++
 rtl/alu1_flag_wb.sv | 151 +++++++++++++++
 tb/tb_alu1_flag_wb.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu1_flag_wb_pkg.sv
// Shared flag definitions for the ALU1 flag writeback stage: bit positions,
// flag vector types and the masked flag-merge helper.
package alu1_flag_wb_pkg;

    localparam int unsigned CF_BIT = 0;
    localparam int unsigned PF_BIT = 1;
    localparam int unsigned AF_BIT = 2;
    localparam int unsigned ZF_BIT = 3;
    localparam int unsigned SF_BIT = 4;
    localparam int unsigned OF_BIT = 5;
    localparam int unsigned DF_BIT = 6;

    typedef logic [5:0] flags6_t;
    typedef logic [6:0] eflags_t;

    // Bits with a set load enable take the new value; all others keep cur.
    function automatic eflags_t merge_flags(
        input eflags_t cur,
        input flags6_t val,
        input flags6_t ld,
        input logic    df_val,
        input logic    ld_df
    );
        eflags_t res;
        res = cur;
        for (int i = 0; i < 6; i++) begin
            if (ld[i]) begin
                res[i] = val[i];
            end else begin
                res[i] = cur[i];
            end
        end
        if (ld_df) begin
            res[DF_BIT] = df_val;
        end else begin
            res[DF_BIT] = cur[DF_BIT];
        end
        return res;
    endfunction

endpackage

// File: rtl/alu1_flag_wb_flag_shadow_reg.sv
// Interrupt shadow copy of the architectural flags. A restore in the same
// cycle as a save wins, so the shadow is left untouched in that case.
module flag_shadow_reg
    import alu1_flag_wb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    save,
    input  logic    restore,
    input  eflags_t save_data,
    output eflags_t shadow
);

    eflags_t shadow_r;

    // Shadow register: cleared on reset, loaded on a save without restore.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_r <= 7'b0000000;
        end else if (save && !restore) begin
            shadow_r <= save_data;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    assign shadow = shadow_r;

endmodule

// File: rtl/alu1_flag_wb.sv
// ALU1 flag execute-to-writeback stage with interrupt save/restore.
// Build option ALU1_FLAG_FWD_EN: forward in-flight CF/AF/DF instead of interlocking.
module alu1_flag_wb
    import alu1_flag_wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_valid,
    output logic       ex_ready,
    input  logic [5:0] alu1_flags,
    input  logic [5:0] cmps_flags,
    input  logic       cmps_sel,
    input  logic       ld_flag_CF,
    input  logic       ld_flag_PF,
    input  logic       ld_flag_AF,
    input  logic       ld_flag_ZF,
    input  logic       ld_flag_SF,
    input  logic       ld_flag_OF,
    input  logic       df_val_ex,
    input  logic       ld_df,
    input  logic       wb_stall,
    input  logic       flush,
    input  logic       isr_entry,
    input  logic       isr_exit,
    output logic [6:0] eflags,
    output logic       wb_valid,
    output logic       CF_fwd,
    output logic       AF_fwd,
    output logic       DF_fwd
);

    flags6_t wb_flags_r;
    flags6_t wb_ld_r;
    logic    wb_df_r;
    logic    wb_ld_df_r;
    logic    wb_valid_r;
    eflags_t eflags_r;

    flags6_t sel_flags_s;
    flags6_t ld_vec_s;
    logic    interlock_s;
    logic    ex_ready_s;
    logic    capture_s;
    logic    commit_s;
    eflags_t merged_s;
    eflags_t eflags_nxt_s;
    logic    wb_valid_nxt_s;
    eflags_t shadow_s;
    logic    cf_fwd_s;
    logic    af_fwd_s;
    logic    df_fwd_s;

    // Source selection and load-enable packing for the incoming result.
    always_comb begin
        sel_flags_s = cmps_sel ? cmps_flags : alu1_flags;
        ld_vec_s    = {ld_flag_OF, ld_flag_SF, ld_flag_ZF,
                       ld_flag_AF, ld_flag_PF, ld_flag_CF};
    end

`ifdef ALU1_FLAG_FWD_EN
    // In-flight CF/AF/DF writers feed ALU1 directly, so no bubble is needed.
    always_comb begin
        interlock_s = 1'b0;
        cf_fwd_s    = (wb_valid_r && wb_ld_r[CF_BIT]) ? wb_flags_r[CF_BIT] : eflags_r[CF_BIT];
        af_fwd_s    = (wb_valid_r && wb_ld_r[AF_BIT]) ? wb_flags_r[AF_BIT] : eflags_r[AF_BIT];
        df_fwd_s    = (wb_valid_r && wb_ld_df_r) ? wb_df_r : eflags_r[DF_BIT];
    end
`else
    // Without forwarding, hold off ALU1 for one cycle behind a CF/AF/DF writer.
    always_comb begin
        interlock_s = wb_valid_r && (wb_ld_r[CF_BIT] || wb_ld_r[AF_BIT] || wb_ld_df_r);
        cf_fwd_s    = eflags_r[CF_BIT];
        af_fwd_s    = eflags_r[AF_BIT];
        df_fwd_s    = eflags_r[DF_BIT];
    end
`endif

    // Handshake, commit decision and next-state for flags and occupancy.
    always_comb begin
        ex_ready_s = rst && !flush && (!wb_valid_r || !wb_stall) && !interlock_s;
        capture_s  = ex_valid && ex_ready_s;
        commit_s   = wb_valid_r && !wb_stall && !flush && !isr_exit;

        if (commit_s) begin
            merged_s = merge_flags(eflags_r, wb_flags_r, wb_ld_r, wb_df_r, wb_ld_df_r);
        end else begin
            merged_s = eflags_r;
        end

        if (isr_exit) begin
            eflags_nxt_s = shadow_s;
        end else if (isr_entry) begin
            eflags_nxt_s         = merged_s;
            eflags_nxt_s[DF_BIT] = 1'b0;
        end else begin
            eflags_nxt_s = merged_s;
        end

        if (capture_s) begin
            wb_valid_nxt_s = 1'b1;
        end else if (commit_s || flush || isr_exit) begin
            wb_valid_nxt_s = 1'b0;
        end else begin
            wb_valid_nxt_s = wb_valid_r;
        end
    end

    // Architectural flags and pipeline register state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            eflags_r   <= 7'b0000000;
            wb_valid_r <= 1'b0;
            wb_flags_r <= 6'b000000;
            wb_ld_r    <= 6'b000000;
            wb_df_r    <= 1'b0;
            wb_ld_df_r <= 1'b0;
        end else begin
            eflags_r   <= eflags_nxt_s;
            wb_valid_r <= wb_valid_nxt_s;
            if (capture_s) begin
                wb_flags_r <= sel_flags_s;
                wb_ld_r    <= ld_vec_s;
                wb_df_r    <= df_val_ex;
                wb_ld_df_r <= ld_df;
            end else begin
                wb_flags_r <= wb_flags_r;
                wb_ld_r    <= wb_ld_r;
                wb_df_r    <= wb_df_r;
                wb_ld_df_r <= wb_ld_df_r;
            end
        end
    end

    // The shadow saves the post-commit flags so a same-cycle writer is kept.
    flag_shadow_reg u_shadow (
        .clk       (clk),
        .rst       (rst),
        .save      (isr_entry),
        .restore   (isr_exit),
        .save_data (merged_s),
        .shadow    (shadow_s)
    );

    assign ex_ready = ex_ready_s;
    assign eflags   = eflags_r;
    assign wb_valid = wb_valid_r;
    assign CF_fwd   = cf_fwd_s;
    assign AF_fwd   = af_fwd_s;
    assign DF_fwd   = df_fwd_s;

endmodule

// File: tb/tb_alu1_flag_wb.sv
// Self-checking bench for alu1_flag_wb: directed vector table, forwarding
// sequence, and randomized traffic against a behavioural flag model.
module tb_alu1_flag_wb;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_valid;
    logic       ex_ready;
    logic [5:0] alu1_flags;
    logic [5:0] cmps_flags;
    logic       cmps_sel;
    logic [5:0] ld;
    logic       df_val_ex;
    logic       ld_df;
    logic       wb_stall;
    logic       flush;
    logic       isr_entry;
    logic       isr_exit;
    logic [6:0] eflags;
    logic       wb_valid;
    logic       CF_fwd;
    logic       AF_fwd;
    logic       DF_fwd;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu1_flag_wb dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .alu1_flags (alu1_flags),
        .cmps_flags (cmps_flags),
        .cmps_sel   (cmps_sel),
        .ld_flag_CF (ld[0]),
        .ld_flag_PF (ld[1]),
        .ld_flag_AF (ld[2]),
        .ld_flag_ZF (ld[3]),
        .ld_flag_SF (ld[4]),
        .ld_flag_OF (ld[5]),
        .df_val_ex  (df_val_ex),
        .ld_df      (ld_df),
        .wb_stall   (wb_stall),
        .flush      (flush),
        .isr_entry  (isr_entry),
        .isr_exit   (isr_exit),
        .eflags     (eflags),
        .wb_valid   (wb_valid),
        .CF_fwd     (CF_fwd),
        .AF_fwd     (AF_fwd),
        .DF_fwd     (DF_fwd)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [5:0] alu;
        logic [5:0] cmps;
        logic       sel;
        logic [5:0] ld;
        logic       df;
        logic       lddf;
        logic       stall;
        logic       flush;
        logic       ent;
        logic       ext;
        logic       chk_rdy;
        logic       rdy;
        logic [6:0] exp_ef;
        logic       exp_wbv;
    } row_t;

    row_t rows[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [5:0] alu, input logic [5:0] cmps,
                       input logic sel, input logic [5:0] l, input logic df, input logic lddf,
                       input logic st, input logic fl, input logic en, input logic ex,
                       input logic cr, input logic rd, input logic [6:0] ef, input logic wv);
        row_t x;
        x.rst = r; x.v = v; x.alu = alu; x.cmps = cmps; x.sel = sel; x.ld = l;
        x.df = df; x.lddf = lddf; x.stall = st; x.flush = fl; x.ent = en; x.ext = ex;
        x.chk_rdy = cr; x.rdy = rd; x.exp_ef = ef; x.exp_wbv = wv;
        rows.push_back(x);
    endtask

    task automatic drive(input logic r, input logic v, input logic [5:0] alu, input logic [5:0] cm,
                         input logic sel, input logic [5:0] l, input logic df, input logic lddf,
                         input logic st, input logic fl, input logic en, input logic ex);
        rst = r; ex_valid = v; alu1_flags = alu; cmps_flags = cm; cmps_sel = sel; ld = l;
        df_val_ex = df; ld_df = lddf; wb_stall = st; flush = fl; isr_entry = en; isr_exit = ex;
    endtask

    // Behavioural model state
    logic [6:0] m_ef, m_sh;
    logic       m_v, m_df, m_ldf;
    logic [5:0] m_wf, m_wl;

    function automatic logic model_ready();
        logic ilock;
`ifdef ALU1_FLAG_FWD_EN
        ilock = 1'b0;
`else
        ilock = m_v && (m_wl[0] || m_wl[2] || m_ldf);
`endif
        return rst && !flush && (!m_v || !wb_stall) && !ilock;
    endfunction

    function automatic logic [2:0] model_fwd();
        logic [2:0] f;
        f = {m_ef[6], m_ef[2], m_ef[0]};
`ifdef ALU1_FLAG_FWD_EN
        if (m_v && m_wl[0]) f[0] = m_wf[0];
        if (m_v && m_wl[2]) f[1] = m_wf[2];
        if (m_v && m_ldf)   f[2] = m_df;
`endif
        return f;
    endfunction

    task automatic model_step(input logic rdy);
        logic [6:0] after;
        logic commit;
        if (!rst) begin
            m_ef = '0; m_sh = '0; m_v = 1'b0; m_wf = '0; m_wl = '0; m_df = 1'b0; m_ldf = 1'b0;
        end else begin
            commit = m_v && !wb_stall && !flush && !isr_exit;
            after = m_ef;
            if (commit) begin
                for (int i = 0; i < 6; i++) if (m_wl[i]) after[i] = m_wf[i];
                if (m_ldf) after[6] = m_df;
            end
            if (isr_exit) begin
                m_ef = m_sh;
            end else if (isr_entry) begin
                m_sh = after;
                m_ef = after & 7'b0111111;
            end else begin
                m_ef = after;
            end
            if (ex_valid && rdy) begin
                m_v = 1'b1; m_wf = cmps_sel ? cmps_flags : alu1_flags; m_wl = ld;
                m_df = df_val_ex; m_ldf = ld_df;
            end else if (commit || flush || isr_exit) begin
                m_v = 1'b0;
            end
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        //  rst v  alu        cmps       sel ld         df lddf st fl en ex cr rd  eflags      wbv
        add(0, 0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000000, 0);
        add(1, 1, 6'b101001, 6'b000000, 0, 6'b111111, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0000000, 1);
        add(1, 0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0101001, 0);
        add(1, 1, 6'b111111, 6'b000000, 0, 6'b111111, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0101001, 1);
        add(1, 0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0111111, 0);
        add(1, 1, 6'b110111, 6'b000000, 0, 6'b001000, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0111111, 1);
        add(1, 0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0110111, 0);
        add(1, 1, 6'b000000, 6'b001000, 1, 6'b001000, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0110111, 1);
        add(1, 1, 6'b000000, 6'b000000, 0, 6'b111111, 0, 0, 1, 0, 0, 0, 1, 0, 7'b0110111, 1);
        add(1, 1, 6'b000000, 6'b000000, 0, 6'b111111, 0, 0, 1, 0, 0, 0, 1, 0, 7'b0110111, 1);
        add(1, 1, 6'b000000, 6'b000000, 0, 6'b111111, 0, 0, 1, 0, 0, 0, 1, 0, 7'b0110111, 1);
        add(1, 0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0111111, 0);
        add(1, 1, 6'b000000, 6'b000000, 0, 6'b111111, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0111111, 1);
        add(1, 1, 6'b111111, 6'b000000, 0, 6'b111111, 0, 0, 0, 1, 0, 0, 1, 0, 7'b0111111, 0);
        add(1, 1, 6'b000011, 6'b000000, 0, 6'b111111, 1, 1, 0, 0, 0, 0, 1, 1, 7'b0111111, 1);
        add(1, 0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1000011, 0);
        add(1, 0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 1, 0, 0, 0, 7'b0000011, 0);
        add(1, 1, 6'b000000, 6'b000000, 0, 6'b111111, 0, 1, 0, 0, 0, 0, 1, 1, 7'b0000011, 1);
        add(1, 0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0);
        add(1, 1, 6'b111111, 6'b000000, 0, 6'b111111, 1, 1, 0, 0, 0, 0, 1, 1, 7'b0000000, 1);
        add(1, 0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0, 1, 0, 0, 7'b1000011, 0);
        add(1, 1, 6'b000100, 6'b000000, 0, 6'b111111, 1, 1, 0, 0, 0, 0, 1, 1, 7'b1000011, 1);
        add(1, 0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 1, 0, 0, 0, 7'b0000100, 0);
        add(1, 0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 1, 1, 0, 0, 7'b1000100, 0);
        add(1, 1, 6'b000000, 6'b000000, 0, 6'b111111, 0, 1, 0, 0, 0, 0, 1, 1, 7'b1000100, 1);
        add(1, 0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0);
        add(1, 0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0, 1, 0, 0, 7'b1000100, 0);
        add(1, 1, 6'b111111, 6'b000000, 0, 6'b111111, 0, 0, 0, 0, 0, 0, 1, 1, 7'b1000100, 1);
        add(0, 0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000000, 0);
        add(1, 0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0);
        add(1, 0, 6'b000000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0000000, 0);

        @(posedge clk); #1;
        foreach (rows[k]) begin
            drive(rows[k].rst, rows[k].v, rows[k].alu, rows[k].cmps, rows[k].sel, rows[k].ld,
                  rows[k].df, rows[k].lddf, rows[k].stall, rows[k].flush, rows[k].ent, rows[k].ext);
            #2;
            if (rows[k].chk_rdy) chk($sformatf("row%0d ex_ready", k), {7'd0, ex_ready}, {7'd0, rows[k].rdy});
            @(posedge clk); #1;
            chk($sformatf("row%0d eflags", k), {1'b0, eflags}, {1'b0, rows[k].exp_ef});
            chk($sformatf("row%0d wb_valid", k), {7'd0, wb_valid}, {7'd0, rows[k].exp_wbv});
        end

        // Forwarding: CF writer in wb while architectural CF is still 0.
        drive(1'b1, 1'b1, 6'b000001, 6'h00, 1'b0, 6'b000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2; chk("fwd cap ex_ready", {7'd0, ex_ready}, 8'd1);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 6'b000000, 6'h00, 1'b0, 6'b000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
`ifdef ALU1_FLAG_FWD_EN
        chk("fwd CF_fwd", {7'd0, CF_fwd}, 8'd1);
        chk("fwd ex_ready", {7'd0, ex_ready}, 8'd1);
`else
        chk("fwd CF_fwd", {7'd0, CF_fwd}, 8'd0);
        chk("fwd ex_ready bubble", {7'd0, ex_ready}, 8'd0);
`endif
        @(posedge clk); #1;
        chk("fwd eflags", {1'b0, eflags}, 8'b00000001);
        drive(1'b1, 1'b0, 6'b000000, 6'h00, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
`ifdef ALU1_FLAG_FWD_EN
        chk("fwd CF_fwd next", {7'd0, CF_fwd}, 8'd0);
`else
        chk("fwd CF_fwd after bubble", {7'd0, CF_fwd}, 8'd1);
        chk("fwd ex_ready after bubble", {7'd0, ex_ready}, 8'd1);
`endif
        @(posedge clk); #1;

        // Randomized traffic against the model; first cycle resets both.
        for (int n = 0; n < 600; n++) begin
            logic rdy;
            logic [2:0] f;
            drive((n == 0) ? 1'b0 : ($urandom_range(0, 49) != 0),
                  1'($urandom_range(0, 3) != 0), 6'($urandom), 6'($urandom), 1'($urandom),
                  6'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0));
            #2;
            rdy = model_ready();
            f = model_fwd();
            if (n != 0) begin
                chk($sformatf("rnd%0d ex_ready", n), {7'd0, ex_ready}, {7'd0, rdy});
                chk($sformatf("rnd%0d fwd", n), {5'd0, DF_fwd, AF_fwd, CF_fwd}, {5'd0, f});
            end
            @(posedge clk);
            model_step(rdy);
            #1;
            chk($sformatf("rnd%0d eflags", n), {1'b0, eflags}, {1'b0, m_ef});
            chk($sformatf("rnd%0d wb_valid", n), {7'd0, wb_valid}, {7'd0, m_v});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
